// File: rtl/regfile_clr.sv
// regfile_clr: parametrised two-read/one-write register bank with a hardware
// clear sequencer, optional write-to-read bypass and optional hard-zero r0.
//
// Ports:
//   clk    in   1      single clock, all state changes on posedge
//   reset  in   1      synchronous active-high reset; starts a full clear
//   clr    in   1      single-cycle request to zero all registers (IDLE only)
//   we3    in   1      write enable
//   wa3    in   AW     write address
//   wd3    in   WIDTH  write data
//   ra1    in   AW     read address, port 1
//   ra2    in   AW     read address, port 2
//   rd1    out  WIDTH  read data, port 1 (combinational)
//   rd2    out  WIDTH  read data, port 2 (combinational)
//   busy   out  1      high while the clear sequencer owns the array
module regfile_clr #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [0:0]       state_r;
  logic [AW-1:0]    ptr_r;
  logic [WIDTH-1:0] regb_r [DEPTH];
  logic             busy_s;
  logic             wr_ok_s;

  assign busy_s = (state_r == ST_CLEAR);
  assign busy   = busy_s;

  // Qualify a normal write: IDLE only, address in range, r0 protected if hard-zero.
  always_comb begin
    wr_ok_s = 1'b0;
    if (state_r == ST_IDLE && we3 && ({1'b0, wa3} < DEPTH_V)) begin
      if ((ZERO_R0 != 0) && (wa3 == {AW{1'b0}})) begin
        wr_ok_s = 1'b0;
      end else begin
        wr_ok_s = 1'b1;
      end
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Read-port priority: busy, hard-zero r0, out of range, bypass, array.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] val;
    if (busy_s) begin
      val = {WIDTH{1'b0}};
    end else if ((ZERO_R0 != 0) && (ra == {AW{1'b0}})) begin
      val = {WIDTH{1'b0}};
    end else if ({1'b0, ra} >= DEPTH_V) begin
      val = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && we3 && (wa3 == ra)) begin
      val = wd3;
    end else begin
      val = regb_r[ra];
    end
    return val;
  endfunction

  // Combinational read ports.
  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

  // Sequencer state, clear pointer and array updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Array is left alone here; the clear that follows zeroes it.
      state_r <= ST_CLEAR;
      ptr_r   <= {AW{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          regb_r[ptr_r] <= {WIDTH{1'b0}};
          if (ptr_r == LAST_PTR) begin
            state_r <= ST_IDLE;
            ptr_r   <= {AW{1'b0}};
          end else begin
            state_r <= ST_CLEAR;
            ptr_r   <= ptr_r + AW'(1);
          end
        end
        ST_IDLE: begin
          // A write alongside clr still lands; the clear overwrites it later.
          if (wr_ok_s) begin
            regb_r[wa3] <= wd3;
          end
          if (clr) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {AW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
            ptr_r   <= {AW{1'b0}};
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          ptr_r   <= {AW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_clr.md
# regfile_clr

Parametrised successor to the CPU's two-read/one-write register bank. It has configurable width and depth, optional write-to-read bypass and an optional hard-zero register 0. It also has a hardware clear sequencer, so no initialisation file is needed and the register contents are deterministic after every reset and on software request. The block sits in the datapath in place of the fixed 16×16 bank, feeding the ALU operand muxes and taking the writeback mux output.

## Interface
- WIDTH, 16: data width of each register.
- DEPTH, 16: number of registers. Legal range 2..256.
- AW, $clog2(DEPTH): address width (derived; do not override).
- BYPASS, 1: 1 makes a same-cycle write visible on the read ports; 0 gives registered-only reads.
- ZERO_R0, 1: 1 makes register 0 read as 0 and discards writes to it.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- clr  in  1  single-cycle request to zero all registers.
- we3  in  1  write enable.
- wa3  in  AW  write address.
- wd3  in  WIDTH  write data.
- ra1, ra2  in  AW  read addresses.
- rd1, rd2  out  WIDTH  read data (combinational from the array, address and bypass).
- busy  out  1  high while the clear sequencer owns the array.

## Operation
- State machine states:
  - CLEAR: pointer ptr (AW bits) walks the array.
  - IDLE: normal access.
- reset=1 at posedge:
  - Next state is CLEAR, ptr=0.
  - Array contents are not touched in that cycle.
  - Held reset keeps state CLEAR with ptr=0.
- CLEAR:
  - Each posedge writes 0 to entry ptr, then ptr increments.
  - The posedge that writes entry DEPTH-1 sets state to IDLE and ptr to 0 (wrap).
  - The sequence takes exactly DEPTH cycles from the first non-reset edge.
- IDLE:
  - At posedge, if we3=1 and wa3<DEPTH, then regb[wa3] is set to wd3.
  - Exception: with ZERO_R0=1 and wa3=0, the write is discarded.
- clr=1 in IDLE:
  - Next state is CLEAR, ptr=0.
  - A write presented in the same cycle is still performed; the clear later overwrites it.
- clr=1 in CLEAR: ignored. The sequence does not restart.
- we3=1 while busy: the write is dropped silently. The issuer must stall on busy.
- Read ports (each port independent, identical rules, in priority order):
  1. busy=1 → 0.
  2. ZERO_R0=1 and ra=0 → 0.
  3. ra≥DEPTH → 0.
  4. BYPASS=1, we3=1, wa3==ra → wd3.
  5. Otherwise → regb[ra].
- busy = (state==CLEAR). It is decoded from a register, with no combinational path from inputs.
- Out-of-range addresses (possible only when DEPTH is not a power of 2): writes are ignored and reads return 0.

## Timing
- After the posedge where reset=1, busy=1, rd1=rd2=0.
- Reset release at edge N: entries 0..DEPTH-1 are cleared at edges N..N+DEPTH-1. busy falls after edge N+DEPTH-1, so it is low in cycle N+DEPTH.
- Write latency:
  - Data is in the array after 1 edge.
  - With BYPASS=1 it is visible on rd* in the same cycle, combinationally.
  - With BYPASS=0 it is visible in the cycle after the edge.
- clr accepted at edge M (IDLE): busy=1 from cycle M+1. The clear occupies edges M+1..M+DEPTH, and busy falls after edge M+DEPTH.
- reset mid-CLEAR: ptr returns to 0 and the full DEPTH-cycle clear restarts after release.
- reset has priority over clr and we3 in the same cycle. A write in a reset cycle is dropped.
- Back-to-back writes to the same address: last edge wins. Each intermediate value is visible through the bypass in its own cycle.

## Test plan
- Reset sequencing: WIDTH=16, DEPTH=16. Hold reset 3 cycles, then release.
  - busy stays high for exactly 16 cycles, then low.
  - Reading every address afterwards returns 0.
  - we3 during busy leaves the entry at 0.
- Basic access: write r5=16'hBEEF, then r9=16'h1234. Next cycle, ra1=5 and ra2=9 return 16'hBEEF and 16'h1234.
- Bypass: same cycle we3=1, wa3=3, wd3=16'hA5A5, ra1=3.
  - BYPASS=1: rd1=16'hA5A5 in that cycle.
  - BYPASS=0: rd1 shows the old value, then 16'hA5A5 next cycle.
- Register 0: write 16'hFFFF to r0 with ZERO_R0=1.
  - rd1 with ra1=0 is 0, including the bypass cycle.
  - With ZERO_R0=0, rd1 is 16'hFFFF.
- clr with a concurrent write: in IDLE assert clr together with a write r7=16'h0042.
  - busy is high next cycle.
  - After DEPTH cycles, r7 reads 0.
  - A second clr pulse mid-clear does not extend busy.
- Reset mid-clear and odd depth: DEPTH=10 (AW=4). Assert reset at ptr=6, then release.
  - busy lasts 10 more cycles.
  - ra1=12 reads 0.
  - A write to wa3=12 has no effect on any of r0..r9.
